// File: rtl/bcd_serial_add_ctrl_if.sv
// Request/result bundle for the digit-serial BCD adder controller.
// The master side issues start/operands; the slave (controller) returns status and result.
interface bcd_serial_add_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                start;
   logic [4*DIGITS-1:0] a;
   logic [4*DIGITS-1:0] b;
   logic                cin;
   logic                busy;
   logic                done;
   logic [4*DIGITS-1:0] sum;
   logic                cout;
   logic                err;

   modport master (output start, a, b, cin, input busy, done, sum, cout, err);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, err);
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one bcd_adder stepped LSD-first, one digit per clock.
// Optional macro BCD_DIGIT_CHECK_EN adds an invalid-digit (>9) flag reported on err.
module bcd_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] raw;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      cout = (raw > 5'd9);
      sum  = cout ? 4'(raw + 5'd6) : raw[3:0];
   end
endmodule

module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4
) (
   input logic                 clk,
   input logic                 rst,
   bcd_serial_add_ctrl_if.slave bus
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t        state;
   logic [W-1:0]  a_sr, b_sr, res_sr, sum_q, res_next;
   logic [CW-1:0] cnt;
   logic          carry, busy_q, done_q, cout_q;
   logic [3:0]    dig_sum;
   logic          dig_cout, last_digit;

   bcd_adder u_digit (
      .a    (a_sr[3:0]),
      .b    (b_sr[3:0]),
      .cin  (carry),
      .sum  (dig_sum),
      .cout (dig_cout)
   );

   // The new digit enters at the top so that after DIGITS steps digit 0 sits in [3:0].
   if (DIGITS == 1) begin : g_one
      assign res_next = dig_sum;
   end else begin : g_many
      assign res_next = {dig_sum, res_sr[W-1:4]};
   end

   assign last_digit = (cnt == CW'(DIGITS - 1));

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  a_sr   <= bus.a;
                  b_sr   <= bus.b;
                  carry  <= bus.cin;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= ADD;
               end else begin
                  state  <= IDLE;
               end
            end
            ADD: begin
               a_sr   <= a_sr >> 4;
               b_sr   <= b_sr >> 4;
               res_sr <= res_next;
               carry  <= dig_cout;
               cnt    <= cnt + 1'b1;
               if (last_digit) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  sum_q  <= res_next;
                  cout_q <= dig_cout;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

`ifdef BCD_DIGIT_CHECK_EN
   logic accept, bad_digit, flag, err_q;

   assign accept = bus.start && (state == IDLE || state == DONE);

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   // The flag is captured with the operands; err only moves on the ADD->DONE edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         if (accept) flag <= bad_digit;
         if (state == ADD && last_digit) err_q <= flag;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: decimal reference model, randomized operands,
// directed carry/back-to-back/reset/operand-change cases; honours BCD_DIGIT_CHECK_EN.
module tb_bcd_serial_add_ctrl;
   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();
   bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         err;
      bit           known;
      int           done_cyc;
   } exp_t;

   exp_t q[$];
   exp_t held;
   int   cyc     = 0;
   int   next_ok = 0;
   int   n_vec   = 0;
   int   n_err   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic longint unsigned bcd2int(input logic [W-1:0] v);
      longint unsigned r = 0;
      for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + {60'd0, v[4*i +: 4]};
      return r;
   endfunction

   function automatic bit valid_bcd(input logic [W-1:0] v);
      for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic exp_t reference(input logic [W-1:0] av, input logic [W-1:0] bv,
                                      input logic c, input int dc);
      exp_t            e;
      longint unsigned tot, lim;
      lim = 1;
      for (int i = 0; i < DIGITS; i++) lim = lim * 10;
      tot    = bcd2int(av) + bcd2int(bv) + {63'd0, c};
      e.cout = (tot >= lim);
      tot    = tot % lim;
      e.sum  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         e.sum[4*i +: 4] = 4'(tot % 10);
         tot = tot / 10;
      end
      e.known    = valid_bcd(av) && valid_bcd(bv);
`ifdef BCD_DIGIT_CHECK_EN
      e.err      = !e.known;
`else
      e.err      = 1'b0;
`endif
      e.done_cyc = dc;
      return e;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] v = '0;
      for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   // Reference timing: an accepted start at edge e completes with done visible after edge e+DIGITS;
   // the controller can take the next start no earlier than edge e+DIGITS+1.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         q.delete();
         held    = '{sum: '0, cout: 1'b0, err: 1'b0, known: 1'b1, done_cyc: 0};
         next_ok = cyc + 1;
      end else if (bus.start && cyc >= next_ok) begin
         q.push_back(reference(bus.a, bus.b, bus.cin, cyc + DIGITS));
         next_ok = cyc + DIGITS + 1;
      end
   end

   always @(negedge clk) begin
      bit exp_done, exp_busy;
      exp_done = (q.size() > 0) && (q[0].done_cyc == cyc);
      exp_busy = (q.size() > 0) && (cyc >= q[0].done_cyc - DIGITS) && (cyc < q[0].done_cyc);
      check("done", {63'd0, bus.done}, {63'd0, exp_done});
      check("busy", {63'd0, bus.busy}, {63'd0, exp_busy});
      if (exp_done) held = q.pop_front();
      if (held.known) begin
         check("sum", {48'd0, bus.sum}, {48'd0, held.sum});
         check("cout", {63'd0, bus.cout}, {63'd0, held.cout});
      end
      check("err", {63'd0, bus.err}, {63'd0, held.err});
   end

   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c, input int gap);
      @(posedge clk); #1;
      bus.a     = av;
      bus.b     = bv;
      bus.cin   = c;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom);
      repeat (DIGITS - 1 + gap) @(posedge clk);
   endtask

   initial begin
      int t;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      issue(16'h1234, 16'h5678, 1'b0, 1);
      issue(16'h9999, 16'h0001, 1'b0, 0);
      issue(16'h0000, 16'h0000, 1'b1, 2);
      issue(16'h9999, 16'h9999, 1'b1, 0);
      issue(16'h0000, 16'h0000, 1'b0, 1);

      // start held high: accepted only from IDLE/DONE, one result every DIGITS+1 cycles
      @(posedge clk); #1;
      bus.a = 16'h0500; bus.b = 16'h0500; bus.cin = 1'b0; bus.start = 1'b1;
      repeat (3 * (DIGITS + 1)) @(posedge clk);
      #1 bus.start = 1'b0;

      // reset during the second ADD cycle abandons the addition
      @(posedge clk); #1;
      bus.a = 16'h4321; bus.b = 16'h1111; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      repeat (2 * DIGITS) @(posedge clk);

      // operands change right after the start edge
      @(posedge clk); #1;
      bus.a = 16'h0001; bus.b = 16'h0002; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = 16'h9999; bus.b = 16'h9999;
      repeat (DIGITS) @(posedge clk);

`ifdef BCD_DIGIT_CHECK_EN
      issue(16'h00A0, 16'h0000, 1'b0, 1);
      issue(16'h0090, 16'h0000, 1'b0, 1);
`endif

      for (int i = 0; i < 40; i++)
         issue(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), $urandom_range(0, 2));

      t = 0;
      while (q.size() > 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      check("drain", 64'(q.size()), 64'd0);
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
